// File: rtl/alu_issue_pipe.sv
// alu_issue_pipe: requester side of the 32-bit ALU datapath. It maps ALUOp/funct to the ALU
//   control code, registers the operands and control for an external combinational ALU (S1),
//   then captures the ALU result and flags into an output register (S2).
// Latency: an op accepted at edge N is presented on out_* after edge N+1. With out_ready_i
//   held high the pipe sustains one op per cycle.
// Backpressure: in_ready_o = !s1_valid | s2_free. A stalled S2 also holds S1, so both the ALU
//   inputs and out_* stay stable for the whole stall.
// Ports:
//   clk_i, rst_i                          clock and synchronous active-low reset
//   in_valid_i / in_ready_o               input handshake
//   alu_op_i, funct_i, rs_data_i,
//   rt_data_i, imm_i, alu_src_i, tag_i    decoded execute-stage operation
//   alu_src1_o, alu_src2_o, alu_ctrl_o    registered ALU operands and control (S1)
//   alu_result_i, alu_zero_i,
//   alu_overflow_i, alu_cout_i            combinational ALU response
//   out_valid_o / out_ready_i             output handshake
//   out_result_o, out_zero_o,
//   out_overflow_o, out_cout_o,
//   out_tag_o, out_illegal_o              registered result beat (S2)
// Optional macro ALU_ISSUE_OVF_TRAP_EN: adds ovf_trap_o and ovf_sticky_o. A beat whose control
//   was add or sub and whose overflow flag was set is flagged as a trap, and its result is
//   forced to zero. ovf_sticky_o latches on the first trapping beat and clears only on reset.
module alu_issue_pipe #(
  parameter int TAG_W    = 5,
  parameter bit SEXT_IMM = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       alu_op_i,
  input  logic [5:0]       funct_i,
  input  logic [31:0]      rs_data_i,
  input  logic [31:0]      rt_data_i,
  input  logic [15:0]      imm_i,
  input  logic             alu_src_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [31:0]      alu_src1_o,
  output logic [31:0]      alu_src2_o,
  output logic [3:0]       alu_ctrl_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_zero_i,
  input  logic             alu_overflow_i,
  input  logic             alu_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_result_o,
  output logic             out_zero_o,
  output logic             out_overflow_o,
  output logic             out_cout_o,
  output logic [TAG_W-1:0] out_tag_o,
`ifdef ALU_ISSUE_OVF_TRAP_EN
  output logic             ovf_trap_o,
  output logic             ovf_sticky_o,
`endif
  output logic             out_illegal_o
);

  logic             s1_valid;
  logic             s1_illegal;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic             s2_free;
  logic             accept;
  logic             s1_adv;

  logic [3:0]       ctrl_d;
  logic             illegal_d;
  logic [31:0]      imm_ext;
  logic [31:0]      src2_d;

  assign s2_free     = !s2_valid || out_ready_i;
  assign in_ready_o  = !s1_valid || s2_free;
  assign accept      = in_valid_i && in_ready_o;
  assign s1_adv      = s1_valid && s2_free;
  assign out_valid_o = s2_valid;

  // ALUOp/funct to ALU control. An unsupported funct issues as an add and is tagged illegal.
  always_comb begin
    ctrl_d    = 4'b0000;
    illegal_d = 1'b0;
    case (alu_op_i)
      2'b00: ctrl_d = 4'b0000;
      2'b01: ctrl_d = 4'b0001;
      2'b11: ctrl_d = 4'b0101;
      default: begin
        case (funct_i)
          6'b100000: ctrl_d = 4'b0000;
          6'b100010: ctrl_d = 4'b0001;
          6'b100100: ctrl_d = 4'b0010;
          6'b100101: ctrl_d = 4'b0011;
          6'b100111: ctrl_d = 4'b0100;
          6'b101010: ctrl_d = 4'b0101;
          default:   illegal_d = 1'b1;
        endcase
      end
    endcase
  end

  assign imm_ext = SEXT_IMM ? {{16{imm_i[15]}}, imm_i} : {16'h0000, imm_i};
  assign src2_d  = alu_src_i ? imm_ext : rt_data_i;

  // S1: issue register. Operands and control load only on accept, so they hold their last
  // values while S1 is empty or stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s1_valid   <= 1'b0;
      s1_illegal <= 1'b0;
      s1_tag     <= '0;
      alu_src1_o <= '0;
      alu_src2_o <= '0;
      alu_ctrl_o <= '0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_illegal <= illegal_d;
        s1_tag     <= tag_i;
        alu_src1_o <= rs_data_i;
        alu_src2_o <= src2_d;
        alu_ctrl_o <= ctrl_d;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic trap_d;
  assign trap_d = ((alu_ctrl_o == 4'b0000) || (alu_ctrl_o == 4'b0001)) && alu_overflow_i;
`endif

  // S2: result register. It captures the ALU response for the op sitting in S1.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      s2_valid       <= 1'b0;
      out_result_o   <= '0;
      out_zero_o     <= 1'b0;
      out_overflow_o <= 1'b0;
      out_cout_o     <= 1'b0;
      out_tag_o      <= '0;
      out_illegal_o  <= 1'b0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
      ovf_trap_o     <= 1'b0;
      ovf_sticky_o   <= 1'b0;
`endif
    end else begin
      if (s1_adv) begin
        s2_valid       <= 1'b1;
`ifdef ALU_ISSUE_OVF_TRAP_EN
        out_result_o   <= trap_d ? 32'h0 : alu_result_i;
        ovf_trap_o     <= trap_d;
        if (trap_d) begin
          ovf_sticky_o <= 1'b1;
        end
`else
        out_result_o   <= alu_result_i;
`endif
        out_zero_o     <= alu_zero_i;
        out_overflow_o <= alu_overflow_i;
        out_cout_o     <= alu_cout_i;
        out_tag_o      <= s1_tag;
        out_illegal_o  <= s1_illegal;
      end else if (out_ready_i) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_pipe.sv
// tb_alu_issue_pipe: directed and random traffic through alu_issue_pipe, driving it with a
//   behavioural ALU and checking every beat against a queue-based model of the pipe.
module tb_alu_issue_pipe;

  localparam int TAG_W = 5;
  localparam bit SEXT  = 1'b1;

  localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_NOR = 4, K_SLT = 5;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [1:0]       alu_op_i;
  logic [5:0]       funct_i;
  logic [31:0]      rs_data_i, rt_data_i;
  logic [15:0]      imm_i;
  logic             alu_src_i;
  logic [TAG_W-1:0] tag_i;
  logic [31:0]      alu_src1_o, alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [31:0]      alu_result_i;
  logic             alu_zero_i, alu_overflow_i, alu_cout_i;
  logic             out_valid_o, out_ready_i;
  logic [31:0]      out_result_o;
  logic             out_zero_o, out_overflow_o, out_cout_o, out_illegal_o;
  logic [TAG_W-1:0] out_tag_o;
`ifdef ALU_ISSUE_OVF_TRAP_EN
  logic             ovf_trap_o, ovf_sticky_o;
`endif

  always #5 clk_i = ~clk_i;

  alu_issue_pipe #(.TAG_W(TAG_W), .SEXT_IMM(SEXT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_op_i(alu_op_i), .funct_i(funct_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .alu_src_i(alu_src_i), .tag_i(tag_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_zero_i(alu_zero_i),
    .alu_overflow_i(alu_overflow_i), .alu_cout_i(alu_cout_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_result_o(out_result_o), .out_zero_o(out_zero_o),
    .out_overflow_o(out_overflow_o), .out_cout_o(out_cout_o),
    .out_tag_o(out_tag_o),
`ifdef ALU_ISSUE_OVF_TRAP_EN
    .ovf_trap_o(ovf_trap_o), .ovf_sticky_o(ovf_sticky_o),
`endif
    .out_illegal_o(out_illegal_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {cout, overflow, result}.
  function automatic logic [33:0] alu_eval(input int kind, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (kind)
      K_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      K_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      K_AND: r = a & b;
      K_OR:  r = a | b;
      K_NOR: r = ~(a | b);
      K_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {c, v, r};
  endfunction

  // Behavioural ALU attached to the issue register.
  logic [33:0] alu_out;
  always_comb begin
    int k;
    case (alu_ctrl_o)
      4'b0001: k = K_SUB;
      4'b0010: k = K_AND;
      4'b0011: k = K_OR;
      4'b0100: k = K_NOR;
      4'b0101: k = K_SLT;
      default: k = K_ADD;
    endcase
    alu_out        = alu_eval(k, alu_src1_o, alu_src2_o);
    alu_result_i   = alu_out[31:0];
    alu_overflow_i = alu_out[32];
    alu_cout_i     = alu_out[33];
    alu_zero_i     = (alu_out[31:0] == 32'h0);
  end

  typedef struct {
    logic [31:0]      res;
    logic             zero, ovf, cout, ill, trap;
    logic [TAG_W-1:0] tag;
    int               acc_edge;
  } beat_t;

  function automatic beat_t model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] rs,
                                  input logic [31:0] rt, input logic [15:0] imm, input logic src,
                                  input logic [TAG_W-1:0] tag);
    beat_t e;
    int kind;
    logic [31:0] b;
    logic [33:0] r;
    e.ill = 1'b0;
    if (op == 2'b00) kind = K_ADD;
    else if (op == 2'b01) kind = K_SUB;
    else if (op == 2'b11) kind = K_SLT;
    else if (f == 6'h20) kind = K_ADD;
    else if (f == 6'h22) kind = K_SUB;
    else if (f == 6'h24) kind = K_AND;
    else if (f == 6'h25) kind = K_OR;
    else if (f == 6'h27) kind = K_NOR;
    else if (f == 6'h2a) kind = K_SLT;
    else begin kind = K_ADD; e.ill = 1'b1; end
    if (!src) b = rt;
    else if (SEXT) b = $signed(imm);
    else b = {16'h0, imm};
    r = alu_eval(kind, rs, b);
    e.zero = (r[31:0] == 32'h0);
    e.ovf  = r[32];
    e.cout = r[33];
    e.tag  = tag;
    e.acc_edge = 0;
`ifdef ALU_ISSUE_OVF_TRAP_EN
    e.trap = ((kind == K_ADD) || (kind == K_SUB)) && r[32];
`else
    e.trap = 1'b0;
`endif
    e.res = e.trap ? 32'h0 : r[31:0];
    return e;
  endfunction

  int           cyc = 0;
  beat_t        exp_q[$];
  logic [31:0]  ret_log[$];
  logic         stall_prev = 1'b0;
  logic [31:0]  held_res;
  logic [TAG_W-1:0] held_tag;
  logic         sticky_m = 1'b0;

  always @(posedge clk_i) cyc++;

  // Scoreboard: handshakes are sampled at the falling edge, one half cycle before the rising
  // edge on which they take effect.
  always @(negedge clk_i) begin
    beat_t e;
    if (!rst_i) begin
      exp_q.delete();
      stall_prev = 1'b0;
      sticky_m   = 1'b0;
    end else begin
      chk("out_valid", out_valid_o, (exp_q.size() > 0) && (exp_q[0].acc_edge < cyc));
      chk("in_ready", in_ready_o, (exp_q.size() < 2) || out_ready_i);
      if (stall_prev) begin
        chk("hold_result", out_result_o, held_res);
        chk("hold_tag", out_tag_o, held_tag);
      end
      if (out_valid_o && out_ready_i) begin
        chk("beat_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("result", out_result_o, e.res);
          chk("zero", out_zero_o, e.zero);
          chk("overflow", out_overflow_o, e.ovf);
          chk("cout", out_cout_o, e.cout);
          chk("tag", out_tag_o, e.tag);
          chk("illegal", out_illegal_o, e.ill);
`ifdef ALU_ISSUE_OVF_TRAP_EN
          chk("trap", ovf_trap_o, e.trap);
          sticky_m = sticky_m | e.trap;
          chk("sticky", ovf_sticky_o, sticky_m);
`endif
          ret_log.push_back(out_result_o);
        end
      end
      if (in_valid_i && in_ready_o) begin
        e = model(alu_op_i, funct_i, rs_data_i, rt_data_i, imm_i, alu_src_i, tag_i);
        e.acc_edge = cyc + 1;
        exp_q.push_back(e);
      end
      stall_prev = out_valid_o && !out_ready_i;
      held_res   = out_result_o;
      held_tag   = out_tag_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_op(input logic [1:0] op, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [15:0] imm, input logic src,
                        input logic [TAG_W-1:0] tag);
    alu_op_i = op; funct_i = f; rs_data_i = rs; rt_data_i = rt;
    imm_i = imm; alu_src_i = src; tag_i = tag;
  endtask

  // Presents one op and returns one step after the edge that accepted it.
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] imm, input logic src,
                       input logic [TAG_W-1:0] tag);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    set_op(op, f, rs, rt, imm, src, tag);
    in_valid_i = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk_i);
      done = in_ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end
    in_valid_i = 1'b0;
    chk("issue_accepted", done, 1);
  endtask

  task automatic drain();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    step(3);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFFFFFF;
      3: return 32'h80000000;
      4: return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] legal_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a};

  initial begin
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    set_op(2'b00, 6'h0, 32'h0, 32'h0, 16'h0, 1'b0, '0);

    // Reset, then idle.
    step(2);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_in_ready", in_ready_o, 1);
    chk("rst_result", out_result_o, 0);
    chk("rst_flags", {out_zero_o, out_overflow_o, out_cout_o, out_illegal_o}, 0);
    chk("rst_tag", out_tag_o, 0);
    chk("rst_alu_ports", {alu_src1_o, alu_src2_o, alu_ctrl_o}, 0);
    rst_i = 1'b1;
    step(2);

    // R-type add with a one-cycle issue-to-result latency.
    issue(2'b10, 6'b100000, 32'd5, 32'd7, 16'h0, 1'b0, 5'd3);
    chk("add_alu_ctrl", alu_ctrl_o, 4'b0000);
    step(1);
    chk("add_valid", out_valid_o, 1);
    chk("add_result", out_result_o, 32'd12);
    chk("add_zero", out_zero_o, 0);
    chk("add_tag", out_tag_o, 3);
    chk("add_illegal", out_illegal_o, 0);
    drain();

    // Sign-extended immediate.
    issue(2'b00, 6'h0, 32'h10, 32'h0, 16'hFFFF, 1'b1, 5'd1);
    chk("imm_src2", alu_src2_o, SEXT ? 32'hFFFFFFFF : 32'h0000FFFF);
    step(1);
    chk("imm_result", out_result_o, SEXT ? 32'h0F : 32'h1000F);
    chk("imm_cout", out_cout_o, SEXT ? 1 : 0);
    drain();

    // Back-pressure with three ops streaming.
    ret_log.delete();
    out_ready_i = 1'b0;
    issue(2'b01, 6'h0, 32'd9, 32'd9, 16'h0, 1'b0, 5'd4);
    issue(2'b10, 6'b100111, 32'd0, 32'd0, 16'h0, 1'b0, 5'd5);
    set_op(2'b11, 6'h0, 32'd1, 32'd2, 16'h0, 1'b0, 5'd6);
    in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready_o, 0);
      chk("bp_hold_result", out_result_o, 0);
      chk("bp_hold_zero", out_zero_o, 1);
      step(1);
    end
    out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_release_ready", in_ready_o, 1);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    step(4);
    chk("bp_count", ret_log.size(), 3);
    if (ret_log.size() == 3) begin
      chk("bp_r0", ret_log[0], 32'h0);
      chk("bp_r1", ret_log[1], 32'hFFFFFFFF);
      chk("bp_r2", ret_log[2], 32'h1);
    end

    // Unsupported funct issues as an add and carries the illegal bit.
    issue(2'b10, 6'b000000, 32'd3, 32'd4, 16'h0, 1'b0, 5'd9);
    chk("ill_alu_ctrl", alu_ctrl_o, 4'b0000);
    step(1);
    chk("ill_flag", out_illegal_o, 1);
    chk("ill_result", out_result_o, 32'd7);
    drain();

`ifdef ALU_ISSUE_OVF_TRAP_EN
    issue(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 16'h0, 1'b0, 5'd2);
    step(1);
    chk("ovf_flag", out_overflow_o, 1);
    chk("ovf_trap", ovf_trap_o, 1);
    chk("ovf_result", out_result_o, 0);
    chk("ovf_sticky", ovf_sticky_o, 1);
    issue(2'b10, 6'b100000, 32'h1, 32'h1, 16'h0, 1'b0, 5'd2);
    step(1);
    chk("ovf_next_trap", ovf_trap_o, 0);
    chk("ovf_next_result", out_result_o, 2);
    chk("ovf_sticky_held", ovf_sticky_o, 1);
    drain();
`endif

    // Reset while the pipe is full and stalled.
    out_ready_i = 1'b0;
    issue(2'b00, 6'h0, 32'd20, 32'd22, 16'h0, 1'b0, 5'd7);
    issue(2'b01, 6'h0, 32'd20, 32'd22, 16'h0, 1'b0, 5'd8);
    rst_i = 1'b0;
    step(1);
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_result", out_result_o, 0);
    chk("mid_rst_ctrl", alu_ctrl_o, 0);
`ifdef ALU_ISSUE_OVF_TRAP_EN
    chk("mid_rst_sticky", ovf_sticky_o, 0);
`endif
    step(3);
    chk("mid_rst_no_emit", out_valid_o, 0);

    // Random traffic with random back-pressure.
    for (int i = 0; i < 800; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      in_valid_i  = ($urandom_range(0, 9) < 7);
      set_op(2'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 5)],
             rand_word(), rand_word(), 16'($urandom), 1'($urandom), TAG_W'($urandom));
      step(1);
    end
    drain();
    chk("drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
